// File: rtl/disp_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disp_stream_arbiter
// Description : Shares one disparity/confidence sink between two decimated
//               pixel streams (left- and right-referenced disparity maps).
//               Grants a whole output row (DEC_FRAME_WIDTH words) at a time.
//               Grants alternate round-robin when both sources are waiting.
//               Each output word carries source, start-of-frame and
//               end-of-line tags.
//
// Ports       : clk, reset          - clock, asynchronous active-high reset
//               in0_* / in1_*       - source word {disp, conf}, valid, ready
//               out_data/out_src    - registered output word and its source
//               out_sof/out_eol     - first word of row 0 / last word of a row
//               out_valid/out_ready - output handshake
//               stall0_cnt/stall1_cnt (DISP_ARB_STATS_EN only) - saturating
//               counts of cycles a source was valid but not accepted
//
// Build option: define DISP_ARB_STATS_EN to add the stall counters.
//
// Revision    : 1.0 - initial release
// ============================================================================
module disp_stream_arbiter #(
    parameter int DISP_BITS        = 5,
    parameter int DEC_FRAME_WIDTH  = 240,
    parameter int DEC_FRAME_HEIGHT = 180
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DISP_BITS+7:0] in0_data,
    input  logic                 in0_valid,
    output logic                 in0_ready,
    input  logic [DISP_BITS+7:0] in1_data,
    input  logic                 in1_valid,
    output logic                 in1_ready,
    output logic [DISP_BITS+7:0] out_data,
    output logic                 out_src,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef DISP_ARB_STATS_EN
    ,
    output logic [15:0]          stall0_cnt,
    output logic [15:0]          stall1_cnt
`endif
);

    localparam int WCW = (DEC_FRAME_WIDTH  > 1) ? $clog2(DEC_FRAME_WIDTH)  : 1;
    localparam int RCW = (DEC_FRAME_HEIGHT > 1) ? $clog2(DEC_FRAME_HEIGHT) : 1;
    localparam logic [WCW-1:0] WORD_LAST = WCW'(DEC_FRAME_WIDTH - 1);
    localparam logic [RCW-1:0] ROW_LAST  = RCW'(DEC_FRAME_HEIGHT - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 grant;
    logic                 grant_nxt;
    logic                 last_grant;
    logic [WCW-1:0]       word_cnt;
    logic [RCW-1:0]       row_cnt0;
    logic [RCW-1:0]       row_cnt1;
    logic                 out_free;
    logic                 xfer0;
    logic                 xfer1;
    logic                 xfer;
    logic                 row_done;
    logic [DISP_BITS+7:0] sel_data;
    logic [RCW-1:0]       sel_row;

    // The output register can take a new word when empty or being drained.
    assign out_free  = !out_valid || out_ready;
    assign in0_ready = (state == BURST) && !grant && out_free;
    assign in1_ready = (state == BURST) &&  grant && out_free;
    assign xfer0     = in0_valid && in0_ready;
    assign xfer1     = in1_valid && in1_ready;
    assign xfer      = xfer0 || xfer1;
    assign row_done  = xfer && (word_cnt == WORD_LAST);
    assign sel_data  = grant ? in1_data : in0_data;
    assign sel_row   = grant ? row_cnt1 : row_cnt0;

    // Next-state: grant is decided only in IDLE and then held for a full
    // row, regardless of input bubbles from the granted source.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    grant_nxt = !last_grant;
                    state_nxt = BURST;
                end else if (in0_valid) begin
                    grant_nxt = 1'b0;
                    state_nxt = BURST;
                end else if (in1_valid) begin
                    grant_nxt = 1'b1;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (row_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant resets to 1 so that source 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (row_done) begin
                last_grant <= grant;
            end
        end
    end

    // Word counter is shared (rows are never split); row counters are per
    // source because each source walks its own frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
            row_cnt0 <= '0;
            row_cnt1 <= '0;
        end else if (xfer) begin
            if (row_done) begin
                word_cnt <= '0;
                if (grant) begin
                    row_cnt1 <= (row_cnt1 == ROW_LAST) ? '0 : row_cnt1 + 1'b1;
                end else begin
                    row_cnt0 <= (row_cnt0 == ROW_LAST) ? '0 : row_cnt0 + 1'b1;
                end
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_src   <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= sel_data;
            out_src   <= grant;
            out_sof   <= (word_cnt == '0) && (sel_row == '0);
            out_eol   <= (word_cnt == WORD_LAST);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DISP_ARB_STATS_EN
    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic [15:0] stall_cnt [2];

    assign src_valid = {in1_valid, in0_valid};
    assign src_ready = {in1_ready, in0_ready};

    for (genvar k = 0; k < 2; k++) begin : g_stall
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stall_cnt[k] <= '0;
            end else if (src_valid[k] && !src_ready[k] &&
                         (stall_cnt[k] != 16'hFFFF)) begin
                stall_cnt[k] <= stall_cnt[k] + 16'd1;
            end
        end
    end

    assign stall0_cnt = stall_cnt[0];
    assign stall1_cnt = stall_cnt[1];
`endif

endmodule
`default_nettype wire

// File: doc/disp_stream_arbiter.md
Name: disp_stream_arbiter

Overview:
- Shares one downstream disparity/confidence sink between two decimated pixel-processing streams (left-referenced and right-referenced disparity maps).
- Grants whole output rows (dec_frame_width words) at a time, alternating round-robin between sources.
- Tags each word with its source, start-of-frame and end-of-line flags.
- Sits between the per-eye output FIFOs and the frame writer / DMA.

Parameters:
- disp_bits, 5, disparity field width; data word width is disp_bits+8 ({disp, conf}).
- dec_frame_width, 240, words per row; this is the burst length per grant.
- dec_frame_height, 180, rows per frame per source; used for the sof flag and row wrap.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in0_data  in  disp_bits+8  source 0 word {disp, conf}.
- in0_valid  in  1  source 0 word available (FIFO not empty).
- in0_ready  out  1  source 0 word consumed this cycle.
- in1_data  in  disp_bits+8  source 1 word.
- in1_valid  in  1  source 1 word available.
- in1_ready  out  1  source 1 word consumed this cycle.
- out_data  out  disp_bits+8  registered output word.
- out_src  out  1  source index of out_data.
- out_sof  out  1  first word of row 0 of that source's frame.
- out_eol  out  1  last word of a row.
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts the word.

Behaviour:
- States:
  - IDLE: no grant held.
  - BURST: grant holds for one row.
- Reset:
  - state=IDLE, grant=0, last_grant=1 (so source 0 is served first).
  - Word counter and both per-source row counters = 0.
  - out_valid=0, out_data=0, out_src=0, out_sof=0, out_eol=0.
  - in0_ready=in1_ready=0. Reset is effective mid-burst; a partial row is dropped and the sink must tolerate it.
- Grant decision in IDLE:
  - Both valid: grant = !last_grant.
  - One valid: grant that source, even if it was served last.
  - None valid: stay in IDLE.
  - Grant is registered; BURST starts the next cycle, so there is 1 idle cycle per row switch.
- Ready:
  - ink_ready = (state==BURST) && (grant==k) && (!out_valid || out_ready). Purely combinational from registers and out_ready.
  - The non-granted source's ready is always 0.
- Transfer: a transfer occurs when ink_valid && ink_ready. On the next edge:
  - out_data <= ink_data, out_src <= k, out_valid <= 1.
  - out_eol <= (word_cnt == dec_frame_width-1).
  - out_sof <= (word_cnt == 0) && (row_cnt[k] == 0).
  - Latency is 1 cycle from input accept to out_valid.
- Output register:
  - If out_valid && out_ready and there is no new transfer, out_valid <= 0.
  - While out_valid && !out_ready, all out_* hold stable and no input is accepted.
- Counters:
  - word_cnt increments per transfer.
  - On the transfer with word_cnt == dec_frame_width-1:
    - word_cnt <= 0, state <= IDLE, last_grant <= grant.
    - row_cnt[grant] increments, wrapping to 0 after dec_frame_height-1.
- A row is never split: the granted source keeps the grant through input bubbles (ink_valid low) for any duration.
- Width rules:
  - word_cnt is $clog2(dec_frame_width) bits.
  - row_cnt is $clog2(dec_frame_height) bits; comparisons are against parameter minus 1.

Optional Feature:
- Macro: DISP_ARB_STATS_EN.
- Defined: adds output ports stall0_cnt and stall1_cnt, 16 bits each. stallk_cnt increments on every cycle where ink_valid=1 and ink_ready=0, saturates at 16'hFFFF, and clears on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Only in0 valid continuously, out_ready=1, dec_frame_width=4 → in0_ready high in 4 consecutive cycles; outputs src=0 with eol on the 4th word; sof=1 on word 0 of row 0 only; 1 idle cycle, then the next row from source 0.
- Both sources valid continuously → rows alternate 0,1,0,1; the first row is from source 0; in1_ready is never high during a source 0 burst.
- out_ready held low for 5 cycles mid-burst → out_* stable for 5 cycles, no ready asserted; resumes with no word lost or duplicated (data checked against an incrementing pattern).
- Source 0 drops valid for 10 cycles mid-row while in1_valid=1 → grant stays on source 0; source 1 is served only after source 0's eol.
- dec_frame_height=2, source 0 only → sof asserted on rows 0 and 2, not on row 1 (row counter wrap).
- Assert reset mid-burst after 2 of 4 words → outputs immediately 0; after release the first grant goes to source 0 with word_cnt=0 and sof=1.
